// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight writer counters that drive the decode stall
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_en,
  input  logic [4:0]      issue_rd,
  output logic            issue_rdy,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic            kill_en,
  input  logic [4:0]      kill_rd,
  input  logic [4:0]      rs_ID,
  input  logic [4:0]      rt_ID,
  output logic            stall_ID,
  output logic [NREG-1:0] pend_vec,
  output logic            err,
  output logic [31:0]     stall_cnt
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [CNT_W-1:0] cnt [NREG];
  logic [CNT_W-1:0] nxt [NREG];
  logic [NREG-1:0] uf;
  logic signed [CNT_W+1:0] s;
  logic issue_ok, ovf, eff_rs, eff_rt;
  assign issue_rdy = (issue_rd == '0) || (cnt[issue_rd] != MAX);
  assign issue_ok = issue_en && issue_rdy && (issue_rd != '0);
  assign ovf = issue_en && !issue_rdy;
  assign eff_rs = (rs_ID != '0) && (cnt[rs_ID] > {{(CNT_W-1){1'b0}}, wb_en && (wb_rd == rs_ID)});
  assign eff_rt = (rt_ID != '0) && (cnt[rt_ID] > {{(CNT_W-1){1'b0}}, wb_en && (wb_rd == rt_ID)});
  assign stall_ID = eff_rs || eff_rt;
  // next counter per register with underflow clamped to zero; register 0 stays zero
  always_comb begin
    uf = '0;
    s = '0;
    for (int i = 0; i < NREG; i++) nxt[i] = '0;
    for (int i = 1; i < NREG; i++) begin
      s = {2'b00, cnt[i]} + (CNT_W+2)'(issue_ok && issue_rd == 5'(i))
        - (CNT_W+2)'(wb_en && wb_rd == 5'(i)) - (CNT_W+2)'(kill_en && kill_rd == 5'(i));
      uf[i] = s < 0;
      nxt[i] = uf[i] ? '0 : s[CNT_W-1:0];
    end
  end
  // pending view of the registered counters
  always_comb begin
    pend_vec = '0;
    for (int i = 1; i < NREG; i++) pend_vec[i] = cnt[i] != '0;
  end
  // counter, sticky error and stall statistics state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt[i] <= nxt[i];
      err <= err || (|uf) || ovf;
      stall_cnt <= stall_cnt + 32'(stall_ID);
    end
  end
endmodule
